// File: rtl/tcdm_bank_arbiter.sv
// Round-robin arbiter merging NumIn master ports onto one single-cycle TCDM bank.
// Responses return to the granted master exactly one cycle after its grant.
module tcdm_bank_arbiter #(
   parameter int unsigned NumIn     = 4,
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [NumIn-1:0]               in_req_i,
   input  logic [NumIn*AddrWidth-1:0]     in_addr_i,
   input  logic [NumIn-1:0]               in_wen_i,
   input  logic [NumIn*DataWidth-1:0]     in_wdata_i,
   input  logic [NumIn*DataWidth/8-1:0]   in_be_i,
   output logic [NumIn-1:0]               in_gnt_o,
   output logic [NumIn-1:0]               in_vld_o,
   output logic [NumIn*DataWidth-1:0]     in_rdata_o,
   output logic                           bank_req_o,
   output logic [AddrWidth-1:0]           bank_addr_o,
   output logic                           bank_wen_o,
   output logic [DataWidth-1:0]           bank_wdata_o,
   output logic [DataWidth/8-1:0]         bank_be_o,
   input  logic [DataWidth-1:0]           bank_rdata_i
);

   localparam int unsigned BeWidth = DataWidth / 8;
   localparam int unsigned IdxW    = $clog2(NumIn);

   logic [IdxW-1:0] r_rr_ptr;
   logic [IdxW-1:0] r_resp_idx;
   logic            r_resp_vld;

   logic [IdxW-1:0] w_win;
   logic [IdxW-1:0] w_ptr_nxt;
   logic            w_found;
   int unsigned     w_j;

   // Scan from the pointer, wrapping; the first requester wins.
   always_comb begin
      w_found      = 1'b0;
      w_win        = '0;
      w_j          = 0;
      in_gnt_o     = '0;
      bank_addr_o  = '0;
      bank_wen_o   = 1'b0;
      bank_wdata_o = '0;
      bank_be_o    = '0;
      for (int unsigned k = 0; k < NumIn; k++) begin
         w_j = (32'(r_rr_ptr) + k) % NumIn;
         if (!w_found && in_req_i[w_j]) begin
            w_found      = 1'b1;
            w_win        = w_j[IdxW-1:0];
            in_gnt_o[w_j] = 1'b1;
            bank_addr_o  = in_addr_i[w_j*AddrWidth +: AddrWidth];
            bank_wen_o   = in_wen_i[w_j];
            bank_wdata_o = in_wdata_i[w_j*DataWidth +: DataWidth];
            bank_be_o    = in_be_i[w_j*BeWidth +: BeWidth];
         end
      end
   end

   assign bank_req_o = |in_req_i;

   assign w_ptr_nxt = (w_win == IdxW'(NumIn - 1)) ? '0 : w_win + 1'b1;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rr_ptr   <= '0;
         r_resp_vld <= 1'b0;
         r_resp_idx <= '0;
      end else begin
         r_resp_vld <= w_found;
         if (w_found) begin
            r_rr_ptr   <= w_ptr_nxt;
            r_resp_idx <= w_win;
         end
      end
   end

   always_comb begin
      in_vld_o             = '0;
      in_vld_o[r_resp_idx] = r_resp_vld;
   end

   assign in_rdata_o = {NumIn{bank_rdata_i}};

   a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0(in_gnt_o));
   a_vld_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0(in_vld_o));
   a_req_gnt : assert property (@(posedge clk_i) disable iff (!rst_ni)
      bank_req_o == (|in_gnt_o));

endmodule
